pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Program-counter generator directly upstream of the fetch stage.
- Drives the word address into fetch's synchronous instruction memory, which has 1-cycle read latency.
- Tracks the PC and valid bit of the instruction currently on fetch's instruction_o, so decode sees {instruction, pc, valid} aligned.
- Handles decode back-pressure (stall) and branch/jump redirects.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset; must be 4-byte aligned.
- TRAP_VECTOR, 32'h0000_0100, byte address taken on a misaligned redirect; used only with MISALIGN_TRAP_EN.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- ready_i  in  1  decode accepts the current instruction this cycle.
- redirect_i  in  1  redirect request (taken branch/jump) from execute.
- redirect_pc_i  in  32  redirect target byte address.
- fetch_addr_o  out  32  word address to fetch pc_i, equal to {2'b00, byte_addr[31:2]}; combinational.
- instr_pc_o  out  32  byte PC of the instruction on fetch instruction_o.
- instr_valid_o  out  1  fetch instruction_o holds a valid instruction.
- fetch_count_o  out  32  number of instructions accepted by decode.
- misalign_o  out  1  misaligned-redirect pulse; present only with MISALIGN_TRAP_EN.

Behaviour:
- State registers:
  - pc_q: next byte PC to fetch.
  - dpc_q: PC of the instruction in the fetch output register, driven on instr_pc_o.
  - valid_q: driven on instr_valid_o.
  - cnt_q: driven on fetch_count_o.
- Reset (rst_i=1 at a clock edge): pc_q=RESET_PC, dpc_q=0, valid_q=0, cnt_q=0, misalign_o=0.
  - While rst_i=1, fetch_addr_o = RESET_PC>>2.
- advance = !valid_q || ready_i. Accept = valid_q && ready_i.
- Address mux, priority high to low:
  - redirect_i=1: fetch_addr_o = target>>2.
  - advance=1: fetch_addr_o = pc_q>>2.
  - otherwise (stall): fetch_addr_o = dpc_q>>2. Fetch re-reads the held instruction, so instruction_o stays stable while stalled.
- Redirect cycle updates: dpc_q<=target, pc_q<=target+4, valid_q<=1.
  - The instruction on instruction_o during the redirect cycle is wrong-path. It is neither counted nor considered accepted, even if ready_i=1.
  - Decode must qualify acceptance with !redirect_i.
  - Redirect penalty is exactly one killed slot.
- Advance cycle updates: dpc_q<=pc_q, pc_q<=pc_q+4, valid_q<=1.
- Stall cycle (valid_q && !ready_i && !redirect_i): all state holds.
- Latency:
  - First cycle after rst_i deasserts presents RESET_PC.
  - instr_valid_o=1 with instr_pc_o=RESET_PC in the following cycle.
  - Then one instruction per cycle while ready_i=1.
- cnt_q increments by 1 on each accept cycle where redirect_i=0. It wraps 0xFFFF_FFFF -> 0.
- PC arithmetic is modulo 2^32: 0xFFFF_FFFC + 4 = 0x0000_0000.
- Fetch decodes only word-address bits [11:0], so PCs alias every 16 KiB. pc_gen does not check this.
- Simultaneous redirect_i and stall: redirect wins, and the stall is released.
- Simultaneous rst_i and redirect_i: reset wins.
- Reset mid-operation: all state is discarded; the behaviour is identical to power-on reset.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - When redirect_i=1 and redirect_pc_i[1:0]!=0, the target becomes TRAP_VECTOR in place of redirect_pc_i.
  - misalign_o is registered high for exactly one cycle, aligned with instr_pc_o=TRAP_VECTOR.
  - Aligned redirects behave as normal.
- Undefined:
  - The misalign_o port is absent.
  - redirect_pc_i[1:0] is ignored, i.e. the target is forced to {redirect_pc_i[31:2], 2'b00}.

Test Plan:
- Reset release, ready_i=1 constant -> cycle 1: valid=1, pc=0x0. Cycle 2: pc=0x4. Cycle 3: pc=0x8. fetch_count_o=3 after cycle 3. instruction_o matches imem[0], imem[1], imem[2].
- Stall: hold ready_i=0 for 3 cycles while pc=0x8 -> instr_pc_o=0x8 and instruction_o=imem[2] stable; fetch_addr_o=2. On ready_i=1, next pc=0xC with no duplicates or skips.
- Redirect: redirect_i=1 with redirect_pc_i=0x40 while pc=0x10 -> next cycle pc=0x40, instruction=imem[16], then 0x44. fetch_count_o does not count the redirect cycle.
- Redirect during stall, and redirect with rst_i=1 -> redirect wins over stall (pc=target next cycle); reset wins over redirect (valid=0, pc_q=RESET_PC).
- Wrap: redirect to 0xFFFF_FFFC with ready_i=1 -> pc sequence 0xFFFF_FFFC then 0x0000_0000; fetch_addr_o=0x3FFF_FFFF then 0.
- MISALIGN_TRAP_EN defined: redirect to 0x42 -> pc=0x100 and misalign_o=1 for one cycle. Undefined: redirect to 0x42 -> pc=0x40.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator feeding a 1-cycle-latency instruction memory.
// Optional build macro MISALIGN_TRAP_EN: misaligned redirects trap to TRAP_VECTOR.
module pc_gen #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
`ifdef MISALIGN_TRAP_EN
   ,
   parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
`endif
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ready_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] fetch_addr_o,
   output logic [31:0] instr_pc_o,
   output logic        instr_valid_o,
   output logic [31:0] fetch_count_o
`ifdef MISALIGN_TRAP_EN
   ,
   output logic        misalign_o
`endif
);

   logic [31:0] r_pc;
   logic [31:0] r_dpc;
   logic        r_valid;
   logic [31:0] r_cnt;

   logic        w_advance;
   logic        w_accept;
   logic [31:0] w_target;
   logic [31:0] w_fetch_byte;

   assign w_advance = !r_valid || ready_i;
   assign w_accept  = r_valid && ready_i && !redirect_i;

`ifdef MISALIGN_TRAP_EN
   logic r_misalign;
   logic w_misaligned;

   assign w_misaligned = redirect_i && (redirect_pc_i[1:0] != 2'b00);
   assign w_target     = w_misaligned ? TRAP_VECTOR : redirect_pc_i;
   assign misalign_o   = r_misalign;
`else
   assign w_target     = redirect_pc_i & ~32'h0000_0003;
`endif

   // Stalls re-read the held PC so the memory output stays stable under back-pressure.
   always_comb begin
      w_fetch_byte = r_dpc;
      if (rst_i)
         w_fetch_byte = RESET_PC;
      else if (redirect_i)
         w_fetch_byte = w_target;
      else if (w_advance)
         w_fetch_byte = r_pc;
   end

   assign fetch_addr_o  = w_fetch_byte >> 2;
   assign instr_pc_o    = r_dpc;
   assign instr_valid_o = r_valid;
   assign fetch_count_o = r_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pc    <= RESET_PC;
         r_dpc   <= 32'h0000_0000;
         r_valid <= 1'b0;
         r_cnt   <= 32'h0000_0000;
      end else begin
         if (redirect_i) begin
            r_dpc   <= w_target;
            r_pc    <= w_target + 32'd4;
            r_valid <= 1'b1;
         end else if (w_advance) begin
            r_dpc   <= r_pc;
            r_pc    <= r_pc + 32'd4;
            r_valid <= 1'b1;
         end
         if (w_accept)
            r_cnt <= r_cnt + 32'd1;
      end
   end

`ifdef MISALIGN_TRAP_EN
   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_misalign <= 1'b0;
      else
         r_misalign <= w_misaligned;
   end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: accepted {pc, instruction} pairs are queued by the
// stimulus and popped by a monitor; per-cycle output expectations travel the same way.
module tb_pc_gen;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        ready_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'h0;
   logic [31:0] fetch_addr_o;
   logic [31:0] instr_pc_o;
   logic        instr_valid_o;
   logic [31:0] fetch_count_o;
   logic [31:0] instruction;
`ifdef MISALIGN_TRAP_EN
   logic        misalign_o;
`endif

   always #5 clk_i = ~clk_i;

   pc_gen dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .ready_i       (ready_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .fetch_addr_o  (fetch_addr_o),
      .instr_pc_o    (instr_pc_o),
      .instr_valid_o (instr_valid_o),
      .fetch_count_o (fetch_count_o)
`ifdef MISALIGN_TRAP_EN
      ,
      .misalign_o    (misalign_o)
`endif
   );

   // Instruction memory stand-in: content encodes the word address it came from.
   always @(posedge clk_i)
      instruction <= 32'hC300_0000 | {20'h0, fetch_addr_o[11:0]};

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   localparam int S_ADDR = 0, S_PC = 1, S_VALID = 2, S_CNT = 3, S_MIS = 4, S_INSTR = 5;

`ifdef MISALIGN_TRAP_EN
   localparam logic [31:0] P_MIS  = 32'h0000_0100;
   localparam logic [31:0] A_MIS  = 32'h0000_0040;
`else
   localparam logic [31:0] P_MIS  = 32'h0000_0040;
   localparam logic [31:0] A_MIS  = 32'h0000_0010;
`endif

   exp_t        dq[$];
   logic [31:0] accq[$];
   int          checks = 0;
   int          failures = 0;
   logic        done = 1'b0;

   task automatic drive(input logic rst, input logic rdy, input logic redir, input logic [31:0] tgt);
      @(posedge clk_i);
      #1;
      rst_i         = rst;
      ready_i       = rdy;
      redirect_i    = redir;
      redirect_pc_i = tgt;
   endtask

   task automatic expect_now(input string name, input int sel, input logic [31:0] exp);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.exp  = exp;
      dq.push_back(e);
   endtask

   function automatic logic [31:0] dut_val(input int sel);
      case (sel)
         S_ADDR:  return fetch_addr_o;
         S_PC:    return instr_pc_o;
         S_VALID: return {31'h0, instr_valid_o};
         S_CNT:   return fetch_count_o;
`ifdef MISALIGN_TRAP_EN
         S_MIS:   return {31'h0, misalign_o};
`endif
         S_INSTR: return instruction;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Monitor: the only process that compares.
   always @(negedge clk_i) begin
      if (!rst_i && instr_valid_o && ready_i && !redirect_i) begin
         checks++;
         if (accq.size() == 0) begin
            failures++;
            $display("FAIL accept_unexpected pc=%h (no accept queued)", instr_pc_o);
         end else begin
            logic [31:0] ep;
            logic [31:0] ei;
            ep = accq.pop_front();
            ei = 32'hC300_0000 | {20'h0, ep[13:2]};
            if (instr_pc_o !== ep || instruction !== ei) begin
               failures++;
               $display("FAIL accept pc=%h instr=%h required pc=%h instr=%h",
                        instr_pc_o, instruction, ep, ei);
            end
         end
      end
      while (dq.size() > 0) begin
         exp_t e;
         logic [31:0] a;
         e = dq.pop_front();
         a = dut_val(e.sel);
         checks++;
         if (a !== e.exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", e.name, a, e.exp);
         end
      end
      if (done) begin
         checks++;
         if (accq.size() != 0) begin
            failures++;
            $display("FAIL accept_drain actual=%0d pending required=0", accq.size());
         end
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $finish;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset
      drive(1, 1, 0, 32'h0);  expect_now("rst_addr", S_ADDR, 32'h0);
      drive(1, 1, 0, 32'h0);
      expect_now("rst_valid", S_VALID, 32'h0);
      expect_now("rst_pc",    S_PC,    32'h0);
      expect_now("rst_cnt",   S_CNT,   32'h0);
      expect_now("rst_addr2", S_ADDR,  32'h0);
`ifdef MISALIGN_TRAP_EN
      expect_now("rst_mis",   S_MIS,   32'h0);
`endif
      // First cycle after release: RESET_PC presented, nothing valid yet
      drive(0, 1, 0, 32'h0);
      expect_now("rel_valid", S_VALID, 32'h0);
      expect_now("rel_addr",  S_ADDR,  32'h0);
      drive(0, 1, 0, 32'h0);  accq.push_back(32'h0);
      expect_now("c1_valid", S_VALID, 32'h1);
      expect_now("c1_addr",  S_ADDR,  32'h1);
      drive(0, 1, 0, 32'h0);  accq.push_back(32'h4);
      // Stall three cycles on pc 0x8
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 32'h0);
         expect_now("stall_pc",    S_PC,    32'h8);
         expect_now("stall_addr",  S_ADDR,  32'h2);
         expect_now("stall_instr", S_INSTR, 32'hC300_0002);
      end
      drive(0, 1, 0, 32'h0);  accq.push_back(32'h8);
      expect_now("cnt_after_stall", S_CNT, 32'd2);
      drive(0, 1, 0, 32'h0);  accq.push_back(32'hC);
      expect_now("cnt_c7", S_CNT, 32'd3);
      // Redirect to 0x40 while pc 0x10 is on the output
      drive(0, 1, 1, 32'h40);
      expect_now("redir_pc",   S_PC,   32'h10);
      expect_now("redir_addr", S_ADDR, 32'h10);
      expect_now("redir_cnt",  S_CNT,  32'd4);
      drive(0, 1, 0, 32'h0);  accq.push_back(32'h40);
      expect_now("redir_nocount", S_CNT, 32'd4);
      drive(0, 1, 0, 32'h0);  accq.push_back(32'h44);
      expect_now("cnt_c10", S_CNT, 32'd5);
      // Redirect during stall
      drive(0, 0, 1, 32'h80);
      expect_now("rstall_pc",   S_PC,   32'h48);
      expect_now("rstall_addr", S_ADDR, 32'h20);
      expect_now("rstall_cnt",  S_CNT,  32'd6);
      drive(0, 1, 0, 32'h0);  accq.push_back(32'h80);
      drive(0, 1, 0, 32'h0);  accq.push_back(32'h84);
      // Misaligned redirect target 0x42
      drive(0, 1, 1, 32'h42);
      expect_now("mis_addr", S_ADDR, A_MIS);
      drive(0, 1, 0, 32'h0);  accq.push_back(P_MIS);
`ifdef MISALIGN_TRAP_EN
      expect_now("mis_pulse", S_MIS, 32'h1);
`endif
      drive(0, 1, 0, 32'h0);  accq.push_back(P_MIS + 32'd4);
`ifdef MISALIGN_TRAP_EN
      expect_now("mis_end", S_MIS, 32'h0);
`endif
      // Wrap at the top of the address space
      drive(0, 1, 1, 32'hFFFF_FFFC);
      expect_now("wrap_addr0", S_ADDR, 32'h3FFF_FFFF);
      expect_now("wrap_pc0",   S_PC,   P_MIS + 32'd8);
      drive(0, 1, 0, 32'h0);  accq.push_back(32'hFFFF_FFFC);
      expect_now("wrap_addr1", S_ADDR, 32'h0);
      drive(0, 1, 0, 32'h0);  accq.push_back(32'h0);
      expect_now("wrap_addr2", S_ADDR, 32'h1);
      expect_now("cnt_c19",    S_CNT,  32'd11);
      // Reset together with redirect: reset wins
      drive(1, 1, 1, 32'h200);
      expect_now("rstredir_addr", S_ADDR, 32'h0);
      drive(0, 1, 0, 32'h0);
      expect_now("rstredir_valid", S_VALID, 32'h0);
      expect_now("rstredir_pc",    S_PC,    32'h0);
      expect_now("rstredir_cnt",   S_CNT,   32'h0);
      expect_now("rstredir_addr2", S_ADDR,  32'h0);
      drive(0, 1, 0, 32'h0);  accq.push_back(32'h0);
      drive(0, 1, 0, 32'h0);  accq.push_back(32'h4);
      drive(0, 0, 0, 32'h0);
      expect_now("final_cnt", S_CNT, 32'd2);
      expect_now("final_pc",  S_PC,  32'h8);
      done = 1'b1;
   end

endmodule
